mash111_noise_cancel: RTL and testbench
=======================================

// Module: mash111_noise_cancel
// PURPOSE
//  Noise-cancellation network (NCL) of a 3rd-order MASH 1-1-1 DDSM.
//  Consumes the 1-bit carry-outs of the three cascaded 8-bit pipelined accumulator stages.
//  Produces the signed multi-bit modulator output y and the divider modulus N_INT+y.
//  Sits directly downstream of the accumulators; feeds the fractional-N divider control.
// PARAMETERS
//  P_ORDER     3    MASH order; legal values 2 or 3 (2: stage-3 carry ignored)
//  P_N_INT     100  integer divide ratio added to y (unsigned)
//  P_DIV_WIDTH 8    width of o_div; must hold P_N_INT+4 and P_N_INT-3
// PORTS
//  i_clk    in   1            clock
//  i_rst_n  in   1            asynchronous, active-low reset
//  i_clr    in   1            sync clear of history/output regs, 1 cycle
//  i_valid  in   1            carries valid this cycle (accumulator sample strobe)
//  i_c1     in   1            carry-out of accumulator stage 1 (bit 7 of its carry vector)
//  i_c2     in   1            carry-out of accumulator stage 2
//  i_c3     in   1            carry-out of accumulator stage 3
//  o_valid  out  1            o_y/o_div updated this cycle
//  o_y      out  4            signed two's-complement y, range -3..+4
//  o_div    out  P_DIV_WIDTH  P_N_INT + o_y, unsigned
// BEHAVIOUR
//  - Reset (i_rst_n low, async): all history regs 0, o_valid=0, o_y=0, o_div=P_N_INT.
//  - History regs advance only on i_valid=1; held otherwise (clock-enable, no bubbles inserted).
//  - Sample index n = n-th accepted i_valid. Per sample:
//      c1d1<=c1, c1d2<=c1d1, c2d1<=c2, c2d2<=c2d1, c3d1<=c3, c3d2<=c3d1.
//  - P_ORDER=3: y[n] = c1[n-2] + (c2[n-1]-c2[n-2]) + (c3[n]-2*c3[n-1]+c3[n-2]).
//  - P_ORDER=2: y[n] = c1[n-1] + (c2[n]-c2[n-1]); i_c3 ignored; y range -1..+2.
//  - Arithmetic in signed 4 bits; no saturation needed (range proven -3..+4).
//  - o_div = P_N_INT + sign-extended y, computed with P_DIV_WIDTH bits, no wrap for legal params.
//  - Latency: o_y/o_div registered; reflect sample n on the cycle after i_valid; o_valid = i_valid delayed 1.
//  - o_valid=0 cycles: o_y/o_div hold the last value.
//  - History starts at 0 after reset/clear: first two outputs use zero history (no priming suppression).
//  - i_clr=1: next edge zeroes history, o_y=0, o_div=P_N_INT, o_valid=0.
//    i_clr wins over a simultaneous i_valid; that sample is dropped.
//  - Reset mid-stream: immediate async clear; first i_valid after release is sample n=0.
//  - Counter: sample count not kept; block is stateless beyond 2-deep delay lines + output reg.
// TESTING
//  1 All carries 0, i_valid=1 every cycle, 20 cycles -> o_y=0, o_div=100 every cycle, o_valid=1 from cycle 1.
//  2 Single i_c3 pulse at sample k, others 0 -> o_y=+1,-2,+1 on cycles k+1,k+2,k+3, then 0; o_div=101,98,101.
//  3 Single i_c1 pulse at sample k -> o_y=+1 only on cycle k+3; single i_c2 pulse -> +1 at k+2, -1 at k+3.
//  4 Extremes: c3 seq 1,0,1, c2 seq 0,1,x, c1=1 at n-2 -> o_y=+4, o_div=104;
//    c3 0,1,0, c2 1,0, c1=0 -> o_y=-3, o_div=97.
//  5 i_valid toggled 1,0,0,1 with c3 pulse -> history frozen during gaps; +1,-2,+1 spread over valid cycles only; o_y held when o_valid=0.
//  6 i_clr and i_valid together mid-stream, then async reset mid-stream -> regs zero, o_y=0, o_div=100, o_valid=0; next samples restart from zero history.

Source files
------------

// File: rtl/mash111_noise_cancel.sv
// Noise-cancellation network of a MASH 1-1-1 (or 1-1) delta-sigma modulator:
// combines the accumulator carry-outs into the signed output y and the divider modulus.
module mash111_noise_cancel #(
    parameter int P_ORDER     = 3,
    parameter int P_N_INT     = 100,
    parameter int P_DIV_WIDTH = 8
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic                   i_clr,
    input  logic                   i_valid,
    input  logic                   i_c1,
    input  logic                   i_c2,
    input  logic                   i_c3,
    output logic                   o_valid,
    output logic [3:0]             o_y,
    output logic [P_DIV_WIDTH-1:0] o_div
);

    localparam logic [P_DIV_WIDTH-1:0] N_INT_W = P_DIV_WIDTH'(P_N_INT);

    // Two-deep delay lines per carry, advanced only on accepted samples
    logic c1d1, c1d2;
    logic c2d1, c2d2;
    logic c3d1, c3d2;

    logic [3:0]             y_next;
    logic [P_DIV_WIDTH-1:0] div_next;

    // Modular 4-bit arithmetic; the result always lies in -3..+4 so no saturation is needed
    always_comb begin
        y_next = 4'd0;
        if (P_ORDER == 2) begin
            y_next = {3'b000, c1d1} + {3'b000, i_c2} - {3'b000, c2d1};
        end else begin
            y_next = {3'b000, c1d2}
                   + {3'b000, c2d1} - {3'b000, c2d2}
                   + {3'b000, i_c3} - {2'b00, c3d1, 1'b0} + {3'b000, c3d2};
        end
    end

    always_comb begin
        div_next = N_INT_W + {{(P_DIV_WIDTH-4){y_next[3]}}, y_next};
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            c1d1    <= 1'b0;
            c1d2    <= 1'b0;
            c2d1    <= 1'b0;
            c2d2    <= 1'b0;
            c3d1    <= 1'b0;
            c3d2    <= 1'b0;
            o_valid <= 1'b0;
            o_y     <= 4'd0;
            o_div   <= N_INT_W;
        end else if (i_clr) begin
            // Clear takes priority: a sample presented alongside it is dropped
            c1d1    <= 1'b0;
            c1d2    <= 1'b0;
            c2d1    <= 1'b0;
            c2d2    <= 1'b0;
            c3d1    <= 1'b0;
            c3d2    <= 1'b0;
            o_valid <= 1'b0;
            o_y     <= 4'd0;
            o_div   <= N_INT_W;
        end else begin
            o_valid <= i_valid;
            if (i_valid) begin
                c1d1  <= i_c1;
                c1d2  <= c1d1;
                c2d1  <= i_c2;
                c2d2  <= c2d1;
                c3d1  <= (P_ORDER == 2) ? 1'b0 : i_c3;
                c3d2  <= c3d1;
                o_y   <= y_next;
                o_div <= div_next;
            end
        end
    end

endmodule

// File: tb/tb_mash111_noise_cancel.sv
// Bench for mash111_noise_cancel: hand-computed vector table, reset/clear sequences,
// and randomized traffic against a sample-history reference model.
module tb_mash111_noise_cancel;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       clr;
    logic       valid;
    logic       c1, c2, c3;
    logic       o_valid;
    logic [3:0] o_y;
    logic [7:0] o_div;

    mash111_noise_cancel #(
        .P_ORDER    (3),
        .P_N_INT    (100),
        .P_DIV_WIDTH(8)
    ) dut (
        .i_clk  (clk),
        .i_rst_n(rst_n),
        .i_clr  (clr),
        .i_valid(valid),
        .i_c1   (c1),
        .i_c2   (c2),
        .i_c3   (c3),
        .o_valid(o_valid),
        .o_y    (o_y),
        .o_div  (o_div)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic v;
        logic cl;
        logic a;
        logic b;
        logic c;
        int   ev;
        int   ey;
        int   ed;
    } vec_t;

    vec_t vecs[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    // Reference model: list of accepted samples since last reset/clear
    int q1[$];
    int q2[$];
    int q3[$];
    int m_valid = 0;
    int m_y     = 0;
    int m_div   = 100;

    function automatic int past(input int which, input int back);
        int idx;
        int sz;
        sz  = (which == 1) ? q1.size() : (which == 2) ? q2.size() : q3.size();
        idx = sz - 1 - back;
        if (idx < 0) return 0;
        if (which == 1) return q1[idx];
        if (which == 2) return q2[idx];
        return q3[idx];
    endfunction

    function automatic void model_reset();
        q1.delete();
        q2.delete();
        q3.delete();
        m_valid = 0;
        m_y     = 0;
        m_div   = 100;
    endfunction

    function automatic void model_step(input logic v, input logic cl, input logic a,
                                       input logic b, input logic c);
        if (cl) begin
            model_reset();
        end else begin
            m_valid = int'(v);
            if (v) begin
                q1.push_back(int'(a));
                q2.push_back(int'(b));
                q3.push_back(int'(c));
                m_y = past(1, 2) + (past(2, 1) - past(2, 2))
                    + (past(3, 0) - 2 * past(3, 1) + past(3, 2));
                m_div = 100 + m_y;
            end
        end
    endfunction

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_model(input string tag);
        check({tag, "_valid"}, int'(o_valid), m_valid);
        check({tag, "_y"}, int'($signed(o_y)), m_y);
        check({tag, "_div"}, int'(o_div), m_div);
    endtask

    task automatic drive_cycle(input logic v, input logic cl, input logic a,
                               input logic b, input logic c);
        valid = v;
        clr   = cl;
        c1    = a;
        c2    = b;
        c3    = c;
        @(posedge clk);
        model_step(v, cl, a, b, c);
        #1;
    endtask

    function automatic void add(input logic v, input logic cl, input logic a, input logic b,
                                input logic c, input int ev, input int ey, input int ed);
        vec_t t;
        t.v = v; t.cl = cl; t.a = a; t.b = b; t.c = c;
        t.ev = ev; t.ey = ey; t.ed = ed;
        vecs.push_back(t);
    endfunction

    initial begin
        rst_n = 1'b0;
        clr   = 1'b0;
        valid = 1'b0;
        c1    = 1'b0;
        c2    = 1'b0;
        c3    = 1'b0;
        model_reset();

        // idle zeros
        for (int i = 0; i < 6; i++) add(1, 0, 0, 0, 0, 1, 0, 100);
        // single c3 pulse: +1, -2, +1
        add(1, 0, 0, 0, 1, 1, 1, 101);
        add(1, 0, 0, 0, 0, 1, -2, 98);
        add(1, 0, 0, 0, 0, 1, 1, 101);
        add(1, 0, 0, 0, 0, 1, 0, 100);
        // single c1 pulse: +1 two samples later
        add(1, 0, 1, 0, 0, 1, 0, 100);
        add(1, 0, 0, 0, 0, 1, 0, 100);
        add(1, 0, 0, 0, 0, 1, 1, 101);
        add(1, 0, 0, 0, 0, 1, 0, 100);
        // single c2 pulse: 0, +1, -1
        add(1, 0, 0, 1, 0, 1, 0, 100);
        add(1, 0, 0, 0, 0, 1, 1, 101);
        add(1, 0, 0, 0, 0, 1, -1, 99);
        add(1, 0, 0, 0, 0, 1, 0, 100);
        // maximum +4 then flush
        add(1, 0, 1, 0, 1, 1, 1, 101);
        add(1, 0, 0, 1, 0, 1, -2, 98);
        add(1, 0, 0, 0, 1, 1, 4, 104);
        add(1, 0, 0, 0, 0, 1, -3, 97);
        add(1, 0, 0, 0, 0, 1, 1, 101);
        add(1, 0, 0, 0, 0, 1, 0, 100);
        // minimum -3
        add(1, 0, 0, 1, 0, 1, 0, 100);
        add(1, 0, 0, 0, 1, 1, 2, 102);
        add(1, 0, 0, 0, 0, 1, -3, 97);
        add(1, 0, 0, 0, 0, 1, 1, 101);
        add(1, 0, 0, 0, 0, 1, 0, 100);
        // valid gaps: history frozen, output held, carries during gaps ignored
        add(1, 0, 0, 0, 1, 1, 1, 101);
        add(0, 0, 1, 1, 1, 0, 1, 101);
        add(0, 0, 0, 1, 1, 0, 1, 101);
        add(1, 0, 0, 0, 0, 1, -2, 98);
        add(0, 0, 1, 0, 1, 0, -2, 98);
        add(1, 0, 0, 0, 0, 1, 1, 101);
        add(1, 0, 0, 0, 0, 1, 0, 100);
        // clear with simultaneous valid mid-stream: sample dropped, history zeroed
        add(1, 0, 0, 0, 1, 1, 1, 101);
        add(1, 1, 1, 1, 1, 0, 0, 100);
        add(1, 0, 0, 0, 0, 1, 0, 100);
        add(1, 0, 0, 0, 0, 1, 0, 100);
        add(1, 0, 0, 0, 0, 1, 0, 100);

        repeat (2) @(posedge clk);
        #1;
        check("reset_valid", int'(o_valid), 0);
        check("reset_y", int'($signed(o_y)), 0);
        check("reset_div", int'(o_div), 100);
        rst_n = 1'b1;

        foreach (vecs[i]) begin
            drive_cycle(vecs[i].v, vecs[i].cl, vecs[i].a, vecs[i].b, vecs[i].c);
            check($sformatf("tbl%0d_valid", i), int'(o_valid), vecs[i].ev);
            check($sformatf("tbl%0d_y", i), int'($signed(o_y)), vecs[i].ey);
            check($sformatf("tbl%0d_div", i), int'(o_div), vecs[i].ed);
        end

        // async reset mid-stream
        drive_cycle(1, 0, 0, 0, 1);
        check_model("pre_rst");
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check("async_rst_valid", int'(o_valid), 0);
        check("async_rst_y", int'($signed(o_y)), 0);
        check("async_rst_div", int'(o_div), 100);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        drive_cycle(1, 0, 0, 0, 0);
        check("post_rst0_y", int'($signed(o_y)), 0);
        check("post_rst0_valid", int'(o_valid), 1);
        drive_cycle(1, 0, 0, 0, 0);
        check("post_rst1_y", int'($signed(o_y)), 0);

        // randomized traffic against the model
        for (int i = 0; i < 400; i++) begin
            drive_cycle(logic'($urandom_range(0, 9) < 7), logic'($urandom_range(0, 99) < 3),
                        logic'($urandom_range(0, 1)), logic'($urandom_range(0, 1)),
                        logic'($urandom_range(0, 1)));
            check_model("rnd");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
